// File: rtl/rx_pkg.sv
// Shared types and helpers for the receive sampler.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        DONE  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int OSR_DEF       = 16;
    localparam int DATA_BITS_DEF = 8;

    // Strobes per frame: one start bit, the data bits, one stop bit.
    function automatic int frame_bits(input int data_bits);
        return data_bits + 2;
    endfunction

    // 2-of-3 vote used when the majority sampler is built in.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sampler_if.sv
// Receive-side signal bundle: raw line in, strobes and byte out.
interface rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic                 serial_in;
    logic                 sr_clk;
    logic                 enable;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 framing_error;

    // The sampler itself.
    modport master (
        input  serial_in,
        output sr_clk, enable, data_out, data_valid, framing_error
    );

    // Line driver / downstream consumer.
    modport slave (
        output serial_in,
        input  sr_clk, enable, data_out, data_valid, framing_error
    );
endinterface

// File: rtl/line_sync.sv
// Multi-flop synchroniser for an asynchronous line that idles high.
module line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the raw line through the chain; reset to the idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];
endmodule

// File: rtl/rx_sampler.sv
// Oversampled UART receive front end: synchronises the line, qualifies the
// start bit, issues one mid-bit strobe per frame bit and assembles the byte.
// Build option RX_MAJORITY_EN: each sample is a 2-of-3 vote around mid-bit,
// with the strobe one cycle later than in the single-sample build.
module rx_sampler
    import rx_pkg::*;
#(
    parameter int OSR         = OSR_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    rx_sampler_if.master  bus
);
    localparam int TICK_W = $clog2(OSR);
    localparam int IDX_W  = $clog2(DATA_BITS + 2);

    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  STOP_IDX  = IDX_W'(frame_bits(DATA_BITS) - 1);
`ifdef RX_MAJORITY_EN
    // Decide one tick after mid so the vote includes mid+1.
    localparam logic [TICK_W-1:0] START_DEC = TICK_W'(OSR / 2);
`else
    localparam logic [TICK_W-1:0] START_DEC = TICK_W'(OSR / 2 - 1);
`endif

    logic                 rx_s;
    logic                 sample_s;
    rx_state_t            state_r, state_s;
    logic [TICK_W-1:0]    tick_r, tick_s;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 stop_r, stop_s;
    logic                 strobe_s;
    logic                 enable_s;

    logic                 sr_clk_r;
    logic                 enable_r;
    logic [DATA_BITS-1:0] data_out_r;
    logic                 data_valid_r;
    logic                 framing_error_r;

    line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.serial_in),
        .q       (rx_s)
    );

`ifdef RX_MAJORITY_EN
    logic [1:0] rx_hist_r;

    // Keep the two previous line values for the 2-of-3 vote.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_hist_r <= 2'b11;
        end else begin
            rx_hist_r <= {rx_hist_r[0], rx_s};
        end
    end

    assign sample_s = maj3(rx_hist_r[1], rx_hist_r[0], rx_s);
`else
    assign sample_s = rx_s;
`endif

    // FSM, tick/bit counters and assembly register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            tick_r  <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            stop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            stop_r  <= stop_s;
        end
    end

    // Next-state, counter updates and the strobe/enable decisions.
    always_comb begin
        state_s  = state_r;
        tick_s   = tick_r;
        idx_s    = idx_r;
        shift_s  = shift_r;
        stop_s   = stop_r;
        strobe_s = 1'b0;
        enable_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_s = START;
                    tick_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_r == START_DEC) begin
                    tick_s = '0;
                    if (!sample_s) begin
                        strobe_s = 1'b1;
                        enable_s = 1'b1;
                        idx_s    = IDX_ONE;
                        state_s  = DATA;
                    end else begin
                        state_s  = IDLE;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            DATA: begin
                enable_s = 1'b1;
                if (tick_r == TICK_LAST) begin
                    tick_s   = '0;
                    strobe_s = 1'b1;
                    if (idx_r == STOP_IDX) begin
                        stop_s  = sample_s;
                        idx_s   = '0;
                        state_s = DONE;
                    end else begin
                        shift_s = {sample_s, shift_r[DATA_BITS-1:1]};
                        idx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            DONE: begin
                if (stop_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered outputs; the byte and status publish while in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_clk_r        <= 1'b0;
            enable_r        <= 1'b0;
            data_out_r      <= '0;
            data_valid_r    <= 1'b0;
            framing_error_r <= 1'b0;
        end else begin
            sr_clk_r        <= strobe_s;
            enable_r        <= enable_s;
            data_valid_r    <= (state_r == DONE);
            framing_error_r <= (state_r == DONE) && !stop_r;
            if (state_r == DONE) begin
                data_out_r <= shift_r;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.sr_clk        = sr_clk_r;
    assign bus.enable        = enable_r;
    assign bus.data_out      = data_out_r;
    assign bus.data_valid    = data_valid_r;
    assign bus.framing_error = framing_error_r;
endmodule

// File: tb/tb_rx_sampler.sv
// Self-checking bench for rx_sampler: frame-level expected-event model plus
// literal checks on strobe count, spacing, latency and received bytes.
module tb_rx_sampler;
    localparam int OSR  = 16;
    localparam int DB   = 8;
    localparam int SYNC = 2;
    localparam int NCYC = 4096;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int FULL = (DB + 2) * OSR;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rx_sampler_if #(.DATA_BITS(DB)) bus ();

    rx_sampler #(.OSR(OSR), .DATA_BITS(DB), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected registered outputs, indexed by the clock edge that sets them.
    bit         exp_stb [NCYC];
    bit         exp_en  [NCYC];
    bit         exp_dv  [NCYC];
    bit         exp_fe  [NCYC];
    logic [7:0] exp_byte[NCYC];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame model: strobes every OSR cycles from mid start bit; enable spans
    // the strobes; data_valid one cycle after the stop strobe.
    task automatic plan(input int s, input logic [7:0] b, input logic stop, input int nstb);
        int first;
        int last;
        first = s + SYNC + OSR / 2 + MAJ;
        last  = first + (nstb - 1) * OSR;
        for (int k = 0; k < nstb; k++) begin
            if (first + k * OSR < NCYC) exp_stb[first + k * OSR] = 1'b1;
        end
        for (int e = first; e <= last; e++) begin
            if (e < NCYC) exp_en[e] = 1'b1;
        end
        if (nstb == DB + 2 && last + 1 < NCYC) begin
            exp_dv[last + 1]   = 1'b1;
            exp_fe[last + 1]   = ~stop;
            exp_byte[last + 1] = b;
        end
    endtask

    // Per-cycle comparison against the model.
    logic [7:0] hold_byte = 8'h00;
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_byte = 8'h00;
        end else if (cyc < NCYC) begin
            if (exp_dv[cyc]) hold_byte = exp_byte[cyc];
            check("sr_clk", 32'(bus.sr_clk), 32'(exp_stb[cyc]));
            check("enable", 32'(bus.enable), 32'(exp_en[cyc]));
            check("data_valid", 32'(bus.data_valid), 32'(exp_dv[cyc]));
            check("framing_error", 32'(bus.framing_error), 32'(exp_fe[cyc]));
            check("data_out", 32'(bus.data_out), 32'(hold_byte));
        end
    end

    // Event monitor feeding the literal checks.
    int stb_cnt, en_cnt, dv_cnt, first_stb, last_stb, first_dv, last_dv;
    logic [7:0] first_dout, last_dout;
    logic       last_fe;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.sr_clk) begin
                if (stb_cnt == 0) first_stb = cyc;
                last_stb = cyc;
                stb_cnt++;
            end
            if (bus.enable) en_cnt++;
            if (bus.data_valid) begin
                if (dv_cnt == 0) begin
                    first_dv   = cyc;
                    first_dout = bus.data_out;
                end
                last_dv   = cyc;
                last_dout = bus.data_out;
                last_fe   = bus.framing_error;
                dv_cnt++;
            end
        end
    end

    task automatic clear_mon();
        stb_cnt = 0; en_cnt = 0; dv_cnt = 0;
        first_stb = -1; last_stb = -1; first_dv = -1; last_dv = -1;
        first_dout = 8'h00; last_dout = 8'h00; last_fe = 1'b0;
    endtask

    task automatic idle(input logic lvl, input int n);
        bus.serial_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Drive a frame from a negedge; cycle c is captured at edge s + c.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int spike_c,
                              input int ncyc, input int nstb, input logic [7:0] exp_b,
                              output int s);
        logic [9:0] bits;
        logic       v;
        bits = {stop, b, 1'b0};
        s = cyc + 1;
        plan(s, exp_b, stop, nstb);
        for (int c = 0; c < ncyc; c++) begin
            v = bits[c / OSR];
            if (c == spike_c) v = ~v;
            bus.serial_in = v;
            @(negedge clk);
        end
    endtask

    int s0, s1;

    initial begin
        bus.serial_in = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #2;
        check("reset sr_clk", 32'(bus.sr_clk), 32'd0);
        check("reset enable", 32'(bus.enable), 32'd0);
        check("reset data_out", 32'(bus.data_out), 32'd0);
        check("reset data_valid", 32'(bus.data_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        idle(1'b1, 5);

        // Byte 0xA5, good stop bit.
        clear_mon();
        send_frame(8'hA5, 1'b1, -1, FULL, DB + 2, 8'hA5, s0);
        idle(1'b1, 10);
        check("a5 strobe count", 32'(stb_cnt), 32'd10);
        check("a5 first strobe", 32'(first_stb - s0), 32'(10 + MAJ));
        check("a5 strobe span", 32'(last_stb - first_stb), 32'd144);
        check("a5 enable cycles", 32'(en_cnt), 32'd145);
        check("a5 valid count", 32'(dv_cnt), 32'd1);
        check("a5 valid latency", 32'(last_dv - last_stb), 32'd1);
        check("a5 latency from line", 32'(last_dv - s0), 32'(155 + MAJ));
        check("a5 data", 32'(last_dout), 32'h0A5);
        check("a5 ferr", 32'(last_fe), 32'd0);

        // 3-cycle glitch, then 0x3C.
        clear_mon();
        idle(1'b0, 3);
        idle(1'b1, 40);
        check("glitch strobes", 32'(stb_cnt), 32'd0);
        check("glitch enable", 32'(en_cnt), 32'd0);
        check("glitch valid", 32'(dv_cnt), 32'd0);
        send_frame(8'h3C, 1'b1, -1, FULL, DB + 2, 8'h3C, s0);
        idle(1'b1, 10);
        check("3c data", 32'(last_dout), 32'h03C);

        // 0x00 with stop 0, line held low, then 0xFF.
        clear_mon();
        send_frame(8'h00, 1'b0, -1, FULL, DB + 2, 8'h00, s0);
        idle(1'b0, 48);
        check("break valid", 32'(dv_cnt), 32'd1);
        check("break data", 32'(last_dout), 32'h000);
        check("break ferr", 32'(last_fe), 32'd1);
        check("break no restrobe", 32'(stb_cnt), 32'd10);
        idle(1'b1, 20);
        clear_mon();
        send_frame(8'hFF, 1'b1, -1, FULL, DB + 2, 8'hFF, s0);
        idle(1'b1, 10);
        check("ff data", 32'(last_dout), 32'h0FF);
        check("ff ferr", 32'(last_fe), 32'd0);

        // Reset at the 5th data strobe of 0x81.
        clear_mon();
        send_frame(8'h81, 1'b1, -1, SYNC + OSR / 2 + MAJ + 5 * OSR, 6, 8'h00, s0);
        @(posedge clk);
        #2;
        check("pre-abort strobe", 32'(bus.sr_clk), 32'd1);
        reset_n = 1'b0;
        bus.serial_in = 1'b1;
        #1;
        check("abort sr_clk", 32'(bus.sr_clk), 32'd0);
        check("abort enable", 32'(bus.enable), 32'd0);
        check("abort data_out", 32'(bus.data_out), 32'd0);
        check("abort data_valid", 32'(bus.data_valid), 32'd0);
        check("abort ferr", 32'(bus.framing_error), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        idle(1'b1, 10);
        check("abort no valid", 32'(dv_cnt), 32'd0);
        send_frame(8'h42, 1'b1, -1, FULL, DB + 2, 8'h42, s0);
        idle(1'b1, 10);
        check("42 data", 32'(last_dout), 32'h042);

        // Back-to-back 0x55, 0xAA.
        clear_mon();
        send_frame(8'h55, 1'b1, -1, FULL, DB + 2, 8'h55, s0);
        send_frame(8'hAA, 1'b1, -1, FULL, DB + 2, 8'hAA, s1);
        idle(1'b1, 10);
        check("b2b valid count", 32'(dv_cnt), 32'd2);
        check("b2b spacing", 32'(last_dv - first_dv), 32'd160);
        check("b2b first data", 32'(first_dout), 32'h055);
        check("b2b second data", 32'(last_dout), 32'h0AA);
        check("b2b ferr", 32'(last_fe), 32'd0);

        // 1-cycle spike at mid of data bit 3 of 0x00: the vote rejects it,
        // a single sample takes it.
        clear_mon();
        send_frame(8'h00, 1'b1, OSR / 2 + 4 * OSR, FULL, DB + 2,
                   (MAJ != 0) ? 8'h00 : 8'h08, s0);
        idle(1'b1, 10);
        check("spike data", 32'(last_dout), (MAJ != 0) ? 32'h000 : 32'h008);
        check("spike first strobe", 32'(first_stb - s0), 32'(10 + MAJ));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rx_sampler.md
Name: rx_sampler

Overview:
Receive front end of the serial link, directly upstream of the bit-in-character counter. Runs on the 16x-oversampled receive clock, synchronises the raw line, detects and qualifies start bits, and generates one mid-bit sample strobe per frame bit. The strobe drives the downstream bit counter and shift logic as sr_clk, and enable frames the character. The block also assembles the frame itself and reports the received byte and framing status.

Parameters:
OSR, 16, oversample ticks per bit; even, >= 8
DATA_BITS, 8, data bits per frame; frame = 1 start + DATA_BITS + 1 stop
SYNC_STAGES, 2, line synchroniser depth; >= 2

Ports:
clk  in  1  oversample clock (OSR x baud)
reset_n  in  1  asynchronous active-low reset
serial_in  in  1  raw asynchronous receive line, idle high
sr_clk  out  1  one-cycle strobe at mid-bit of each frame bit, including start and stop
enable  out  1  high while a qualified frame is in progress; feeds downstream counter enable
data_out  out  DATA_BITS  last received byte, LSB first on wire; holds until next frame
data_valid  out  1  one-cycle pulse: data_out updated
framing_error  out  1  one-cycle pulse, coincident with data_valid, when stop bit sampled 0

Behaviour:
- Reset: asynchronous, active-low. Clock is clk. All outputs 0, data_out 0, synchroniser flops 1, state IDLE, counters 0. Assertion mid-frame aborts immediately. No data_valid for the aborted frame.
- Synchroniser: SYNC_STAGES flops. The line seen by the FSM (rx_s) lags serial_in by SYNC_STAGES cycles.
- States: IDLE, START, DATA, DONE, BREAK.
- IDLE: rx_s==0 -> START, tick counter cleared.
- START: tick counter increments each cycle. At tick OSR/2-1 (mid start bit), rx_s is sampled:
  - rx_s==0: sr_clk pulses, enable rises the same cycle, tick counter reset to 0, bit index = 1 -> DATA.
  - rx_s==1: false start, return to IDLE, no sr_clk, enable stays 0.
- DATA: tick counter counts 0..OSR-1 and wraps. At tick OSR-1 (one bit period after the previous strobe), rx_s is sampled, sr_clk pulses, and bit index increments.
  - Data bits shift into the assembly register LSB first.
  - The strobe for bit index DATA_BITS+1 is the stop bit. It is captured separately, then -> DONE.
- enable: high from the start-bit strobe through the stop-bit strobe inclusive, so exactly DATA_BITS+2 strobes occur while enable is high. Low in DONE.
- DONE (one cycle): data_out <= assembly register, data_valid=1, framing_error = ~stop_sample.
  - Stop bit 1 -> IDLE.
  - Stop bit 0 -> BREAK.
- BREAK: wait for rx_s==1, then IDLE. This prevents a held-low line retriggering.
- Latency: data_valid occurs 1 cycle after the stop-bit sr_clk. For default parameters, that is 8+9*16+1 = 153 cycles after rx_s first goes low.
- Back-to-back frames: a start edge present during DONE is accepted. DONE goes to IDLE, which sees rx_s==0 next cycle, costing 1 cycle of the half-bit window; this is acceptable.
- Counter widths: tick counter is $clog2(OSR) bits. Bit index is $clog2(DATA_BITS+2) bits. Neither wraps outside the defined ranges.
- sr_clk is a data strobe in the clk domain, not a derived clock. Downstream logic must use it as a clock enable or accept a glitch-free registered pulse. It is registered here.

Optional Feature:
- Macro: RX_MAJORITY_EN.
- Defined: each sample is the 2-of-3 majority of rx_s at ticks (mid-1, mid, mid+1). The strobe is issued at mid+1, adding 1 cycle to strobe timing and latency (154 cycles default). Start qualification uses the majority too.
- Undefined: single sample at mid tick exactly as above.

Decomposition:
- Package rx_pkg:
  - state enum rx_state_t {IDLE, START, DATA, DONE, BREAK}
  - default constants OSR_DEF=16, DATA_BITS_DEF=8
  - function frame_bits(DATA_BITS)
- Sub-module: line_sync (parameterised SYNC_STAGES, reset to 1). Instantiated once; reused by the transmit-side loopback checker.

Test Plan:
- Byte 0xA5, stop=1, OSR=16: exactly 10 sr_clk pulses spaced 16 cycles apart (first at rx_s fall + 8); enable high covers all 10; data_valid 1 cycle after the last pulse with data_out=0xA5, framing_error=0.
- 3-cycle low glitch on idle line -> no sr_clk, enable stays 0, no data_valid; a following valid 0x3C frame is received correctly.
- Frame 0x00 with stop bit 0 -> data_valid with data_out=0x00, framing_error=1; FSM stays in BREAK while the line is low, no new strobes; line high then frame 0xFF -> data_out=0xFF, framing_error=0.
- reset_n low at the 5th data strobe of a 0x81 frame -> all outputs 0 asynchronously, data_out stays 0, no data_valid; after release, frame 0x42 received correctly.
- Back-to-back 0x55, 0xAA with no idle gap -> two data_valid pulses 160 cycles apart, correct values, no framing errors.
- RX_MAJORITY_EN defined: a 1-cycle inverted spike exactly at mid-bit of data bit 3 of 0x00 -> data_out=0x00; strobe times shifted +1 cycle vs. the default build.
